block_distribution_ctrl: RTL and testbench
==========================================

BLOCK_DISTRIBUTION_CTRL -- requirements
Module: block_distribution_ctrl

Interface
REQ-001 Parameter LEN_CODED_BLOCK, default 66, coded block width in bits.
REQ-002 Parameter N_LANES, default 20, number of PCS lanes; legal range 2..32.
REQ-003 Parameter AM_PERIOD, default 16383, data rounds between alignment-marker rounds; legal range 1..65535.
REQ-004 The block SHALL have one clock, and the reset SHALL be asynchronous and active-low.
REQ-005 i_clock  input  1  sole clock; all state updates on rising edge.
REQ-006 i_reset_n  input  1  asynchronous active-low reset.
REQ-007 i_valid  input  1  upstream block present on i_data.
REQ-008 i_data  input  LEN_CODED_BLOCK  upstream coded block.
REQ-009 i_flush  input  1  synchronous restart request.
REQ-010 o_ready  output  1  block can accept i_data this cycle.
REQ-011 o_data  output  LEN_CODED_BLOCK  write data to the lane memory.
REQ-012 o_addr  output  $clog2(N_LANES)  lane write address.
REQ-013 o_enable  output  1  lane memory write strobe.
REQ-014 o_am_insert  output  1  current write is an alignment-marker slot.
REQ-015 o_round_done  output  1  one-cycle pulse when the last lane of a round is written.

Function
REQ-016 The FSM SHALL have two states: DIST (distribute data) and AM (alignment-marker sweep).
REQ-017 o_ready SHALL equal (state==DIST) && !i_flush, combinationally.
REQ-018 A transfer SHALL occur on a cycle with i_valid && o_ready; no transfer means no write.
REQ-019 On a transfer, on the next edge: o_data = i_data, o_addr = lane counter, o_enable = 1, o_am_insert = 0. Latency is 1 cycle.
REQ-020 On a cycle without a transfer in DIST, o_enable SHALL be 0 on the next edge; o_data and o_addr SHALL hold.
REQ-021 The lane counter SHALL increment on each transfer and wrap from N_LANES-1 to 0.
REQ-022 A transfer at lane N_LANES-1 SHALL increment the round counter and produce o_round_done = 1 alongside that write.
REQ-023 When the transfer at lane N_LANES-1 completes round number AM_PERIOD (round counter AM_PERIOD-1), the round counter SHALL clear and the state SHALL go to AM.
REQ-024 In AM, the block SHALL issue one write per cycle for lanes 0..N_LANES-1 with o_enable = 1, o_am_insert = 1 and o_data = 0, ignoring i_valid.
REQ-025 The AM lane-N_LANES-1 write SHALL assert o_round_done, and the state SHALL return to DIST with the lane counter at 0.
REQ-026 AM rounds SHALL NOT advance the round counter.
REQ-027 i_flush = 1 in any state SHALL, at the next edge, set the state to DIST and clear the lane and round counters. It SHALL also set o_enable, o_am_insert and o_round_done to 0; o_data and o_addr SHALL hold.
REQ-028 i_flush and i_valid asserted in the same cycle: flush wins, no write occurs, and the block is not consumed.
REQ-029 Continuous i_valid SHALL sustain one write per cycle in DIST; upstream stalls only during the N_LANES AM cycles.

Reset
REQ-030 While i_reset_n = 0, outputs SHALL be: o_data = 0, o_addr = 0, o_enable = 0, o_am_insert = 0, o_round_done = 0.
REQ-031 While i_reset_n = 0: state = DIST, lane counter = 0, round counter = 0, o_ready = 1 if i_flush = 0.
REQ-032 Reset asserted mid-round or mid-AM SHALL abort immediately with no partial write after release.
REQ-033 The first write after release SHALL target lane 0.

Verification (N_LANES=20, AM_PERIOD=2)
REQ-034 Reset release, then 20 blocks 0x1..0x14 with i_valid continuous -> o_addr 0..19 on consecutive cycles with o_data = 0x1..0x14; o_round_done is high only with addr 19.
REQ-035 40 continuous blocks -> after the 40th write, o_ready is low for 20 cycles and 20 writes occur with o_am_insert = 1, o_data = 0, addr 0..19; then the 41st block is written at addr 0.
REQ-036 i_valid toggling 1,0,1,0 -> writes only on the cycles after accepted blocks; o_addr advances only on writes.
REQ-037 i_flush with i_valid at lane 7 -> no write; the next accepted block goes to addr 0 and the AM sweep occurs only after 40 further blocks.
REQ-038 i_flush during AM sweep at lane 5 -> sweep aborts, o_ready = 1 next cycle, and the next block goes to addr 0.
REQ-039 i_reset_n pulsed low at lane 12 -> all outputs 0 during reset; the first block after release goes to addr 0.

Source files
------------

// File: rtl/block_distribution_ctrl_if.sv
// Upstream block handshake plus lane-memory write port of the block distributor.
// master = upstream/driver side, slave = distributor side.
interface block_distribution_ctrl_if #(
  parameter int LEN_CODED_BLOCK = 66,
  parameter int N_LANES         = 20
);
  localparam int ADDR_W = $clog2(N_LANES);

  logic                       i_valid;
  logic [LEN_CODED_BLOCK-1:0] i_data;
  logic                       i_flush;
  logic                       o_ready;
  logic [LEN_CODED_BLOCK-1:0] o_data;
  logic [ADDR_W-1:0]          o_addr;
  logic                       o_enable;
  logic                       o_am_insert;
  logic                       o_round_done;

  modport master (
    output i_valid, i_data, i_flush,
    input  o_ready, o_data, o_addr, o_enable, o_am_insert, o_round_done
  );

  modport slave (
    input  i_valid, i_data, i_flush,
    output o_ready, o_data, o_addr, o_enable, o_am_insert, o_round_done
  );
endinterface

// File: rtl/block_distribution_ctrl.sv
// Round-robin distributor of coded blocks over PCS lanes with periodic alignment-marker sweeps; 1-cycle write latency.
// Upstream is stalled only during the N_LANES-cycle AM sweep or while flushing.
module block_distribution_ctrl #(
  parameter int LEN_CODED_BLOCK = 66,
  parameter int N_LANES         = 20,
  parameter int AM_PERIOD       = 16383
) (
  input  logic                      i_clock,
  input  logic                      i_reset_n,
  block_distribution_ctrl_if.slave  bus
);

  localparam int ADDR_W = $clog2(N_LANES);
  localparam int RND_W  = (AM_PERIOD > 1) ? $clog2(AM_PERIOD) : 1;

  localparam logic [ADDR_W-1:0] LAST_LANE  = ADDR_W'(N_LANES - 1);
  localparam logic [RND_W-1:0]  LAST_ROUND = RND_W'(AM_PERIOD - 1);

  typedef enum logic {
    ST_DIST = 1'b0,
    ST_AM   = 1'b1
  } state_t;

  state_t                     state;
  logic [ADDR_W-1:0]          lane_cnt;
  logic [RND_W-1:0]           round_cnt;
  logic [LEN_CODED_BLOCK-1:0] data_q;
  logic [ADDR_W-1:0]          addr_q;
  logic                       enable_q;
  logic                       am_insert_q;
  logic                       round_done_q;

  logic                       last_lane;

  assign last_lane = (lane_cnt == LAST_LANE);

  // Ready must drop in the flush cycle itself so a coincident block is not consumed.
  assign bus.o_ready      = (state == ST_DIST) && !bus.i_flush;
  assign bus.o_data       = data_q;
  assign bus.o_addr       = addr_q;
  assign bus.o_enable     = enable_q;
  assign bus.o_am_insert  = am_insert_q;
  assign bus.o_round_done = round_done_q;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state        <= ST_DIST;
      lane_cnt     <= '0;
      round_cnt    <= '0;
      data_q       <= '0;
      addr_q       <= '0;
      enable_q     <= 1'b0;
      am_insert_q  <= 1'b0;
      round_done_q <= 1'b0;
    end else if (bus.i_flush) begin
      // Restart; the write port data/address are left holding their last values.
      state        <= ST_DIST;
      lane_cnt     <= '0;
      round_cnt    <= '0;
      enable_q     <= 1'b0;
      am_insert_q  <= 1'b0;
      round_done_q <= 1'b0;
    end else begin
      case (state)
        ST_DIST: begin
          am_insert_q <= 1'b0;
          if (bus.i_valid) begin
            data_q       <= bus.i_data;
            addr_q       <= lane_cnt;
            enable_q     <= 1'b1;
            round_done_q <= last_lane;
            if (last_lane) begin
              lane_cnt <= '0;
              if (round_cnt == LAST_ROUND) begin
                round_cnt <= '0;
                state     <= ST_AM;
              end else begin
                round_cnt <= round_cnt + RND_W'(1);
              end
            end else begin
              lane_cnt <= lane_cnt + ADDR_W'(1);
            end
          end else begin
            enable_q     <= 1'b0;
            round_done_q <= 1'b0;
          end
        end

        ST_AM: begin
          // Marker slots carry zero payload; the round counter is left untouched.
          data_q       <= '0;
          addr_q       <= lane_cnt;
          enable_q     <= 1'b1;
          am_insert_q  <= 1'b1;
          round_done_q <= last_lane;
          if (last_lane) begin
            lane_cnt <= '0;
            state    <= ST_DIST;
          end else begin
            lane_cnt <= lane_cnt + ADDR_W'(1);
          end
        end

        default: begin
          state    <= ST_DIST;
          lane_cnt <= '0;
          enable_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_block_distribution_ctrl.sv
// Randomized bench for block_distribution_ctrl against a count-based lane/round model.
module tb_block_distribution_ctrl;

  localparam int LEN = 66;
  localparam int N   = 20;
  localparam int P   = 2;
  localparam int AW  = $clog2(N);
  localparam int VW  = 1 + LEN + AW + 3;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  block_distribution_ctrl_if #(.LEN_CODED_BLOCK(LEN), .N_LANES(N)) vif ();

  block_distribution_ctrl #(
    .LEN_CODED_BLOCK(LEN),
    .N_LANES        (N),
    .AM_PERIOD      (P)
  ) dut (
    .i_clock  (clk),
    .i_reset_n(rst_n),
    .bus      (vif.slave)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Model: blocks accepted since last restart, and position within a pending AM sweep (-1 = none).
  int             n_acc;
  int             am_pos;
  logic           exp_ready;
  logic [LEN-1:0] exp_data;
  logic [AW-1:0]  exp_addr;
  logic           exp_en, exp_am, exp_done;
  logic           act_ready;
  logic [VW-1:0]  act_vec, exp_vec;

  function automatic logic [LEN-1:0] rand_blk();
    logic [LEN-1:0] d;
    d[65:64] = 2'($urandom);
    d[63:32] = $urandom;
    d[31:0]  = $urandom;
    return d;
  endfunction

  task automatic model_restart();
    n_acc    = 0;
    am_pos   = -1;
    exp_data = '0;
    exp_addr = '0;
    exp_en   = 1'b0;
    exp_am   = 1'b0;
    exp_done = 1'b0;
  endtask

  // Drive one cycle from a negedge, advance the model, sample at the following negedge.
  task automatic step(input logic v, input logic [LEN-1:0] d, input logic f);
    vif.i_valid = v;
    vif.i_data  = d;
    vif.i_flush = f;
    #1;
    exp_ready = (am_pos < 0) && !f;
    act_ready = vif.o_ready;
    if (f) begin
      exp_en = 1'b0; exp_am = 1'b0; exp_done = 1'b0;
      n_acc  = 0;
      am_pos = -1;
    end else if (am_pos >= 0) begin
      exp_data = '0;
      exp_addr = AW'(am_pos);
      exp_en   = 1'b1;
      exp_am   = 1'b1;
      exp_done = (am_pos == N - 1);
      am_pos++;
      if (am_pos == N) am_pos = -1;
    end else if (v) begin
      exp_data = d;
      exp_addr = AW'(n_acc % N);
      exp_en   = 1'b1;
      exp_am   = 1'b0;
      exp_done = ((n_acc % N) == N - 1);
      n_acc++;
      if ((n_acc % (N * P)) == 0) am_pos = 0;
    end else begin
      exp_en = 1'b0; exp_am = 1'b0; exp_done = 1'b0;
    end
    @(negedge clk);
    cyc++;
    act_vec = {act_ready, vif.o_data, vif.o_addr, vif.o_enable, vif.o_am_insert, vif.o_round_done};
    exp_vec = {exp_ready, exp_data, exp_addr, exp_en, exp_am, exp_done};
  endtask

  task automatic test_reset();
    logic [VW-1:0] act;
    rst_n = 1'b0;
    vif.i_valid = 1'b1; vif.i_data = rand_blk(); vif.i_flush = 1'b0;
    repeat (3) @(negedge clk);
    act = {vif.o_ready, vif.o_data, vif.o_addr, vif.o_enable, vif.o_am_insert, vif.o_round_done};
    n_cmp++;
    if (act !== {1'b1, {(VW-1){1'b0}}}) begin
      n_err++;
      $display("FAIL reset_state act=%h req=%h", act, {1'b1, {(VW-1){1'b0}}});
    end
    vif.i_valid = 1'b0;
    rst_n = 1'b1;
    model_restart();
  endtask

  task automatic test_round();
    for (int i = 1; i <= N; i++) begin
      step(1'b1, LEN'(i), 1'b0);
      n_cmp++;
      if (act_vec !== exp_vec) begin
        n_err++;
        $display("FAIL round blk%0d act=%h req=%h", i, act_vec, exp_vec);
      end
    end
  endtask

  task automatic test_am_sweep();
    int stalls = 0;
    for (int i = 0; i < 3 * N; i++) begin
      step(1'b1, rand_blk(), 1'b0);
      if (!act_ready) stalls++;
      n_cmp++;
      if (act_vec !== exp_vec) begin
        n_err++;
        $display("FAIL am_sweep cyc%0d act=%h req=%h", cyc, act_vec, exp_vec);
      end
    end
    n_cmp++;
    if (stalls != N) begin
      n_err++;
      $display("FAIL am_stall_cycles act=%0d req=%0d", stalls, N);
    end
  endtask

  task automatic test_toggle();
    for (int i = 0; i < 12; i++) begin
      step(i[0] == 1'b0, rand_blk(), 1'b0);
      n_cmp++;
      if (act_vec !== exp_vec) begin
        n_err++;
        $display("FAIL toggle i%0d act=%h req=%h", i, act_vec, exp_vec);
      end
    end
  endtask

  task automatic test_flush_dist();
    step(1'b0, '0, 1'b1);
    for (int i = 0; i < 7; i++) step(1'b1, rand_blk(), 1'b0);
    // Flush with a coincident block at lane 7: nothing written, nothing consumed.
    step(1'b1, rand_blk(), 1'b1);
    n_cmp++;
    if (act_vec !== exp_vec) begin
      n_err++;
      $display("FAIL flush_dist act=%h req=%h", act_vec, exp_vec);
    end
    for (int i = 0; i < 2 * N * P + 2; i++) begin
      step(1'b1, rand_blk(), 1'b0);
      n_cmp++;
      if (act_vec !== exp_vec) begin
        n_err++;
        $display("FAIL flush_dist_after i%0d act=%h req=%h", i, act_vec, exp_vec);
      end
    end
  endtask

  task automatic test_flush_am();
    step(1'b0, '0, 1'b1);
    for (int i = 0; i < N * P + 5; i++) step(1'b1, rand_blk(), 1'b0);
    n_cmp++;
    if (act_vec !== exp_vec || am_pos != 5) begin
      n_err++;
      $display("FAIL flush_am_setup act=%h req=%h pos=%0d", act_vec, exp_vec, am_pos);
    end
    step(1'b1, rand_blk(), 1'b1);
    n_cmp++;
    if (act_vec !== exp_vec) begin
      n_err++;
      $display("FAIL flush_am act=%h req=%h", act_vec, exp_vec);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, rand_blk(), 1'b0);
      n_cmp++;
      if (act_vec !== exp_vec) begin
        n_err++;
        $display("FAIL flush_am_after i%0d act=%h req=%h", i, act_vec, exp_vec);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [VW-1:0] act;
    step(1'b0, '0, 1'b1);
    for (int i = 0; i < 12; i++) step(1'b1, rand_blk(), 1'b0);
    vif.i_valid = 1'b1; vif.i_data = rand_blk(); vif.i_flush = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    act = {vif.o_ready, vif.o_data, vif.o_addr, vif.o_enable, vif.o_am_insert, vif.o_round_done};
    n_cmp++;
    if (act !== {1'b1, {(VW-1){1'b0}}}) begin
      n_err++;
      $display("FAIL reset_mid act=%h req=%h", act, {1'b1, {(VW-1){1'b0}}});
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_restart();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, rand_blk(), 1'b0);
      n_cmp++;
      if (act_vec !== exp_vec) begin
        n_err++;
        $display("FAIL reset_mid_after i%0d act=%h req=%h", i, act_vec, exp_vec);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, rand_blk(), $urandom_range(0, 59) == 0);
      n_cmp++;
      if (act_vec !== exp_vec) begin
        n_err++;
        $display("FAIL random cyc%0d act=%h req=%h", cyc, act_vec, exp_vec);
      end
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    vif.i_valid = 1'b0;
    vif.i_data  = '0;
    vif.i_flush = 1'b0;
    model_restart();
    @(negedge clk);
    test_reset();
    test_round();
    test_am_sweep();
    test_toggle();
    test_flush_dist();
    test_flush_am();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
